frame_config_writer: RTL and testbench



---
 rtl/frame_cfg_pkg.sv | 44 ++++
 rtl/frame_strobe_decoder.sv | 39 +++
 rtl/frame_config_writer.sv | 151 +++++++++++++++
 tb/tb_frame_config_writer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_cfg_pkg.sv
// Shared types and constants for the fabric configuration frame writer.
// Pure declarations; no logic, no latency.
// Header field positions are kept here so writer and any future reader agree.
package frame_cfg_pkg;

    // Writer sequencing: collect header and rows, then a guarded strobe pulse
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hFA;

    // Header word layout: [31:24] sync, [23:16] column, [15:8] frame, [7:0] unused
    localparam int HDR_FIELD_W   = 8;
    localparam int HDR_SYNC_LSB  = 24;
    localparam int HDR_COL_LSB   = 16;
    localparam int HDR_FRAME_LSB = 8;

    function automatic logic [7:0] hdr_sync(input logic [31:0] word);
        return word[HDR_SYNC_LSB +: HDR_FIELD_W];
    endfunction

    function automatic logic [7:0] hdr_column(input logic [31:0] word);
        return word[HDR_COL_LSB +: HDR_FIELD_W];
    endfunction

    function automatic logic [7:0] hdr_frame(input logic [31:0] word);
        return word[HDR_FRAME_LSB +: HDR_FIELD_W];
    endfunction

    // A header addresses a real strobe only with the right sync and in-range indices
    function automatic logic header_ok(input logic [31:0] word,
                                       input int num_columns,
                                       input int frames_per_col);
        return (hdr_sync(word) == SYNC_BYTE) &&
               (int'(hdr_column(word)) < num_columns) &&
               (int'(hdr_frame(word)) < frames_per_col);
    endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decode of (column, frame, enable) into the FrameStrobe vector.
// Latency: 1 cycle from enable to strobe; output is a flop so it cannot glitch.
// No backpressure; the strobe simply follows enable one cycle later.
module frame_strobe_decoder #(
    parameter int MaxFramesPerCol = 20,
    parameter int NumColumns      = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [7:0]                            column,
    input  logic [7:0]                            frame,
    input  logic                                  enable,
    output logic [NumColumns*MaxFramesPerCol-1:0] strobe
);

    logic [NumColumns*MaxFramesPerCol-1:0] onehot;

    // Full compare per bit so an out-of-range index can never select a strobe
    always_comb begin
        onehot = '0;
        for (int c = 0; c < NumColumns; c++) begin
            for (int f = 0; f < MaxFramesPerCol; f++) begin
                if (enable && (column == 8'(c)) && (frame == 8'(f))) begin
                    onehot[c*MaxFramesPerCol + f] = 1'b1;
                end
            end
        end
    end

    // Strobe register, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe <= '0;
        end else begin
            strobe <= onehot;
        end
    end

endmodule

// File: rtl/frame_config_writer.sv
// Assembles a column-height frame from header + NumRows words and pulses one FrameStrobe bit.
// Latency: last word at edge t -> strobe high after t+2..t+1+StrobeCycles, ready after t+2+StrobeCycles.
// Backpressure: s_ready high only while collecting (IDLE/LOAD); low from SETUP through HOLD.
module frame_config_writer
    import frame_cfg_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumRows         = 4,
    parameter int NumColumns      = 4,
    parameter int StrobeCycles    = 2
) (
    input  logic                                  UserCLK,
    input  logic                                  Reset,
    input  logic [31:0]                           s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  busy,
    output logic                                  err,
    output logic [15:0]                           frames_written
);

    localparam int ROW_W = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int STB_W = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NumRows - 1);
    localparam logic [STB_W-1:0] LAST_STB = STB_W'(StrobeCycles - 1);

    state_t                              state;
    state_t                              state_next;
    logic [ROW_W-1:0]                    row_cnt;
    logic [STB_W-1:0]                    strobe_cnt;
    logic [7:0]                          column_q;
    logic [7:0]                          frame_q;
    logic [NumRows*FrameBitsPerRow-1:0]  frame_data_q;
    logic                                err_q;
    logic [15:0]                         frames_written_q;
    logic                                accept;
    logic                                hdr_good;
    logic                                strobe_en;

    assign accept   = s_valid && s_ready;
    assign hdr_good = header_ok(s_data, NumColumns, MaxFramesPerCol);

    // State register
    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: rows are collected only after a good header; the strobe phase is fixed-length
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (s_valid && hdr_good) state_next = LOAD;
            LOAD:    if (s_valid && (row_cnt == LAST_ROW)) state_next = SETUP;
            SETUP:   state_next = STROBE;
            STROBE:  if (strobe_cnt == LAST_STB) state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state. The decoder flop delays the strobe by one cycle,
    // so SETUP plus the first STROBE cycle give two cycles of data setup margin
    always_comb begin
        s_ready   = 1'b0;
        busy      = 1'b1;
        strobe_en = 1'b0;
        case (state)
            IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
            end
            LOAD:    s_ready   = 1'b1;
            STROBE:  strobe_en = 1'b1;
            default: ;
        endcase
    end

    // Header latch and row counter
    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            column_q <= '0;
            frame_q  <= '0;
            row_cnt  <= '0;
        end else if (accept && (state == IDLE) && hdr_good) begin
            column_q <= hdr_column(s_data);
            frame_q  <= hdr_frame(s_data);
            row_cnt  <= '0;
        end else if (accept && (state == LOAD)) begin
            row_cnt  <= row_cnt + 1'b1;
        end
    end

    // Frame data only moves on a LOAD acceptance, so it is frozen around the strobe
    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            frame_data_q <= '0;
        end else if (accept && (state == LOAD)) begin
            frame_data_q[row_cnt*FrameBitsPerRow +: FrameBitsPerRow] <= FrameBitsPerRow'(s_data);
        end
    end

    // Strobe-length counter, reloaded whenever the FSM is outside STROBE
    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            strobe_cnt <= '0;
        end else if (state == STROBE) begin
            strobe_cnt <= strobe_cnt + 1'b1;
        end else begin
            strobe_cnt <= '0;
        end
    end

    // Sticky bad-header flag and completed-frame counter (wraps naturally)
    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            err_q            <= 1'b0;
            frames_written_q <= '0;
        end else begin
            if (accept && (state == IDLE) && !hdr_good) begin
                err_q <= 1'b1;
            end
            if (state == HOLD) begin
                frames_written_q <= frames_written_q + 16'd1;
            end
        end
    end

    frame_strobe_decoder #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .NumColumns      (NumColumns)
    ) u_strobe_decoder (
        .clk    (UserCLK),
        .reset  (Reset),
        .column (column_q),
        .frame  (frame_q),
        .enable (strobe_en),
        .strobe (FrameStrobe)
    );

    assign FrameData      = frame_data_q;
    assign err            = err_q;
    assign frames_written = frames_written_q;

endmodule

// File: tb/tb_frame_config_writer.sv
module tb_frame_config_writer;

    localparam int S = 2;

    logic          clk = 1'b0;
    logic          Reset;
    logic [31:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic [127:0]  FrameData;
    logic [79:0]   FrameStrobe;
    logic          busy;
    logic          err;
    logic [15:0]   frames_written;

    logic [31:0]   b_data;
    logic          b_valid;
    logic          b_ready;
    logic [127:0]  b_fd;
    logic [39:0]   b_strobe;
    logic          b_busy;
    logic          b_err;
    logic [15:0]   b_fw;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    frame_config_writer dut (
        .UserCLK(clk), .Reset(Reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy), .err(err),
        .frames_written(frames_written)
    );

    frame_config_writer #(.NumColumns(2), .StrobeCycles(1)) dut_b (
        .UserCLK(clk), .Reset(Reset), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
        .FrameData(b_fd), .FrameStrobe(b_strobe), .busy(b_busy), .err(b_err),
        .frames_written(b_fw)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Timeline model: k counts edges since the last data word of a command was taken
    int           m_k    = -1;
    bit           m_in   = 0;
    int           m_rows = 0;
    int           m_col  = 0;
    int           m_frm  = 0;
    logic [127:0] m_fd   = '0;
    bit           m_err  = 0;
    logic [15:0]  m_cnt  = '0;
    bit           preload = 0;
    bit           chk_en  = 0;

    task automatic model_step();
        if (Reset) begin
            m_k = -1; m_in = 0; m_rows = 0; m_fd = '0; m_err = 0; m_cnt = '0;
        end else begin
            if (preload) m_cnt = 16'hFFFE;
            if (m_k >= 0) begin
                if (m_k == S + 1) begin
                    m_k = -1;
                    m_cnt = m_cnt + 16'd1;
                end else begin
                    m_k++;
                end
            end else if (s_valid) begin
                if (!m_in) begin
                    if (s_data[31:24] == 8'hFA && s_data[23:16] < 8'd4 && s_data[15:8] < 8'd20) begin
                        m_in = 1; m_rows = 0;
                        m_col = int'(s_data[23:16]);
                        m_frm = int'(s_data[15:8]);
                    end else begin
                        m_err = 1;
                    end
                end else begin
                    m_fd[m_rows*32 +: 32] = s_data;
                    m_rows++;
                    if (m_rows == 4) begin
                        m_in = 0;
                        m_k = 0;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of every output against the model
    initial forever begin
        logic [79:0] exp_stb;
        @(negedge clk);
        if (chk_en) begin
            exp_stb = '0;
            if (m_k >= 2 && m_k <= S + 1) exp_stb[m_col*20 + m_frm] = 1'b1;
            chk("s_ready", 128'(s_ready), 128'(m_k < 0));
            chk("busy", 128'(busy), 128'(m_in || m_k >= 0));
            chk("err", 128'(err), 128'(m_err));
            chk("frames_written", 128'(frames_written), 128'(m_cnt));
            chk("FrameStrobe", 128'(FrameStrobe), 128'(exp_stb));
            chk("FrameData", FrameData, m_fd);
        end
    end

    // Present one word and wait (bounded) for the handshake; returns cycles spent not ready
    task automatic send(input bit b, input logic [31:0] d, output int waited);
        waited = 0;
        if (b) begin b_valid = 1'b1; b_data = d; end
        else   begin s_valid = 1'b1; s_data = d; end
        while (((b ? b_ready : s_ready) !== 1'b1) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            errors++;
            checks++;
            $display("FAIL handshake_timeout: got no ready expected ready within 50 cycles");
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        b_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic command(input logic [31:0] hdr, input logic [31:0] base);
        int w;
        send(0, hdr, w);
        for (int i = 0; i < 4; i++) send(0, base + 32'(i), w);
        idle(6);
    endtask

    initial begin
        int w;
        int first;
        int hi;
        logic [127:0] fd0;
        logic [31:0] bad [3];
        int gaps [4];

        Reset = 1'b1; s_valid = 1'b0; s_data = '0; b_valid = 1'b0; b_data = '0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        Reset = 1'b0;
        chk("rst_s_ready", 128'(s_ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        chk("rst_fw", 128'(frames_written), 128'd0);
        chk("rst_strobe", 128'(FrameStrobe), 128'd0);
        chk("rst_fd", FrameData, 128'd0);
        idle(1);

        // Basic back-to-back command, column 1 frame 3 -> bit 23
        send(0, 32'hFA010300, w);
        send(0, 32'h11111111, w);
        send(0, 32'h22222222, w);
        send(0, 32'h33333333, w);
        send(0, 32'h44444444, w);
        s_valid = 1'b0;
        first = -1; hi = 0;
        for (int j = 0; j < 6; j++) begin
            if (FrameStrobe[23] === 1'b1) begin
                if (first < 0) first = j;
                hi++;
            end
            @(negedge clk);
        end
        chk("t1_strobe_start", 128'(first), 128'd2);
        chk("t1_strobe_len", 128'(hi), 128'd2);
        chk("t1_fd", FrameData, 128'h44444444_33333333_22222222_11111111);
        chk("t1_fw", 128'(frames_written), 128'd1);

        // Bad headers are consumed and dropped
        bad[0] = 32'hFB000000; bad[1] = 32'hFA040000; bad[2] = 32'hFA001400;
        for (int i = 0; i < 3; i++) begin
            send(0, bad[i], w);
            s_valid = 1'b0;
            chk("bad_err", 128'(err), 128'd1);
            chk("bad_idle", 128'(busy), 128'd0);
        end
        command(32'hFA000000, 32'hA0A0A0A0);
        chk("bad_then_good_fw", 128'(frames_written), 128'd2);
        chk("bad_then_good_fd", FrameData, 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0);

        // Gapped data to the last strobe bit, then next header held high through the strobe
        gaps[0] = 2; gaps[1] = 0; gaps[2] = 3; gaps[3] = 1;
        send(0, 32'hFA031300, w);
        for (int i = 0; i < 4; i++) begin
            idle(gaps[i]);
            send(0, 32'hC0000000 + 32'(i), w);
        end
        send(0, 32'hFA020500, w);
        chk("held_hdr_wait", 128'(w), 128'(S + 2));
        for (int i = 0; i < 4; i++) send(0, 32'hD0000000 + 32'(i), w);
        idle(6);
        chk("gap_fw", 128'(frames_written), 128'd4);

        // Counter wrap from a preloaded value
        force dut.frames_written_q = 16'hFFFE;
        preload = 1;
        @(negedge clk);
        release dut.frames_written_q;
        preload = 0;
        idle(1);
        command(32'hFA000100, 32'h12340000);
        chk("wrap_ffff", 128'(frames_written), 128'hFFFF);
        command(32'hFA000200, 32'h56780000);
        chk("wrap_zero", 128'(frames_written), 128'h0000);
        chk("wrap_err_sticky", 128'(err), 128'd1);

        // Second configuration: 2 columns, single-cycle strobe on column 1 frame 19 -> bit 39
        send(1, 32'hFA011300, w);
        for (int i = 0; i < 4; i++) send(1, 32'hB0000000 + 32'(i), w);
        b_valid = 1'b0;
        fd0 = b_fd;
        chk("b_fd", fd0, 128'hB0000003_B0000002_B0000001_B0000000);
        @(negedge clk);
        chk("b_pre_strobe", 128'(b_strobe), 128'd0);
        chk("b_pre_fd", b_fd, fd0);
        @(negedge clk);
        chk("b_strobe", 128'(b_strobe), 128'(40'h80_0000_0000));
        chk("b_strobe_fd", b_fd, fd0);
        @(negedge clk);
        chk("b_post_strobe", 128'(b_strobe), 128'd0);
        chk("b_post_fd", b_fd, fd0);
        idle(3);
        chk("b_fw", 128'(b_fw), 128'd1);

        // Reset in the middle of a load discards the partial frame
        send(0, 32'hFA000100, w);
        send(0, 32'hEEEEEEE0, w);
        send(0, 32'hEEEEEEE1, w);
        s_valid = 1'b0;
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        chk("mid_rst_fd", FrameData, 128'd0);
        chk("mid_rst_strobe", 128'(FrameStrobe), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        idle(1);
        command(32'hFA010000, 32'h55550000);
        chk("after_rst_fd", FrameData, 128'h55550003_55550002_55550001_55550000);
        chk("after_rst_fw", 128'(frames_written), 128'd1);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
